// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl: Z80 mode-2 interrupt controller for the SD8 system.
//
// NUM_SRC external edge-triggered sources plus one internal periodic timer
// (index NUM_SRC). Fixed priority (lowest index wins), per-source mask,
// write-1-to-clear pending and a programmable vector base. Sits on the CPU
// I/O bus, drives T80s INT_n and supplies the vector byte during the
// interrupt-acknowledge cycle.
//
// Register map (I/O BASE_ADDR + addr[1:0]):
//   0  R/W  mask[NUM_SRC:0]; unused bits read 0
//   1  R    pending (no read side effect); W1C clears written 1 bits
//   2  R/W  vec_base; bit 0 forced to 0
//   3  R/W  bit0 timer_en, bit1 timer_restart (write-only, reads 0),
//           bit7 reads 1 while the acknowledge FSM is in ACK
//
// Ports:
//   clk            CPU clock (cpu_clock)
//   reset_n        synchronous active-low reset
//   iorq_n, m1_n   Z80 bus strobes (IORQ_n && M1_n low together = int ack)
//   rd_n, wr_n     Z80 read/write strobes
//   addr[7:0]      Z80 A[7:0]
//   din[7:0]       CPU write data
//   src[NUM_SRC-1:0] asynchronous interrupt requests, rising edge significant
//   dout[7:0]      register read data or vector byte
//   sel            dout must be selected by the top-level cpu_din mux
//   irq_n          to T80s INT_n (registered)
//   dbg_ack_state  1 while the acknowledge FSM is in ACK
//
// Bus handshake: there is no valid/ready pair here. A register access is
// qualified by reg_sel for as long as the CPU holds the strobes; writes are
// applied on every clk edge they are held and are idempotent. An acknowledge
// is ack = !iorq_n && !m1_n; the vector is latched on the first edge of ack
// and held on dout until ack drops.
module z80_irq_ctrl #(
  parameter int          NUM_SRC   = 2,
  parameter logic [7:0]  BASE_ADDR = 8'h50,
  parameter int          TIMER_DIV = 80000,
  parameter logic [7:0]  RESET_VEC = 8'h20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               iorq_n,
  input  logic               m1_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         addr,
  input  logic [7:0]         din,
  input  logic [NUM_SRC-1:0] src,
  output logic [7:0]         dout,
  output logic               sel,
  output logic               irq_n,
  output logic               dbg_ack_state
);

  localparam int          NB       = NUM_SRC + 1;
  localparam logic [23:0] DIV_LAST = 24'(TIMER_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_t;

  ack_state_t state_q, state_d;

  logic [NB-1:0]      mask_q;
  logic [NB-1:0]      pend_q;
  logic [NB-1:0]      pend_d;
  logic [NB-1:0]      eligible;
  logic [NB-1:0]      set_bits;
  logic [NB-1:0]      clr_bits;
  logic [NB-1:0]      win_onehot;
  logic [7:0]         vec_base_q;
  logic [7:0]         vec_q;
  logic [7:0]         vec_live;
  logic               timer_en_q;
  logic [23:0]        cnt_q;
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] edge_q;
  logic               irq_n_q;
  logic               reg_sel;
  logic               ack;
  logic               ack_start;
  logic               wr_en;
  logic               restart_wr;
  logic               tick;
  logic [2:0]         win;

  // Reads are not strobe-qualified: the top-level mux only looks at sel.
  logic unused_rd;
  assign unused_rd = rd_n;

  assign reg_sel    = !iorq_n && m1_n && (addr[7:2] == BASE_ADDR[7:2]);
  assign ack        = !iorq_n && !m1_n;
  assign wr_en      = reg_sel && !wr_n;
  assign restart_wr = wr_en && (addr[1:0] == 2'd3) && din[1];
  assign tick       = timer_en_q && (cnt_q == DIV_LAST);
  assign eligible   = pend_q & mask_q;
  assign ack_start  = (state_q == ST_IDLE) && ack;

  // Lowest eligible index wins; 3'b111 marks a spurious acknowledge.
  always_comb begin : winner
    win        = 3'b111;
    win_onehot = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win           = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign vec_live = {vec_base_q[7:4], win, 1'b0};

  // Sets (edge or timer tick) override clears (W1C or acknowledge).
  always_comb begin : pending_next
    set_bits = {tick, sync2_q & ~edge_q};
    clr_bits = '0;
    if (wr_en && (addr[1:0] == 2'd1)) clr_bits = clr_bits | din[NB-1:0];
    if (ack_start)                    clr_bits = clr_bits | win_onehot;
    pend_d = (pend_q & ~clr_bits) | set_bits;
  end

  always_comb begin : ack_fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ack)  state_d = ST_ACK;
      ST_ACK:  if (!ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      pend_q     <= '0;
      vec_base_q <= RESET_VEC;
      vec_q      <= '0;
      timer_en_q <= 1'b0;
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      edge_q     <= '0;
      irq_n_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sync1_q <= src;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      pend_q  <= pend_d;

      if (ack_start) vec_q <= vec_live;

      // Held high for the whole acknowledge; the edge where ack has dropped
      // looks at pending again so a second source can re-request at once.
      irq_n_q <= ack ? 1'b1 : !(|eligible);

      if (wr_en && (addr[1:0] == 2'd0)) mask_q     <= din[NB-1:0];
      if (wr_en && (addr[1:0] == 2'd2)) vec_base_q <= {din[7:1], 1'b0};
      if (wr_en && (addr[1:0] == 2'd3)) timer_en_q <= din[0];

      // Re-enabling while enabled leaves the count alone; restart zeroes it.
      if (!timer_en_q || restart_wr || tick) cnt_q <= '0;
      else                                   cnt_q <= cnt_q + 24'd1;
    end
  end

  always_comb begin : read_mux
    dout = 8'h00;
    if (!reset_n) begin
      dout = 8'h00;
    end else if (ack) begin
      // Before the latch edge show the live winner so the byte is stable.
      dout = (state_q == ST_ACK) ? vec_q : vec_live;
    end else if (reg_sel) begin
      case (addr[1:0])
        2'd0:    dout = 8'(mask_q);
        2'd1:    dout = 8'(pend_q);
        2'd2:    dout = vec_base_q;
        default: dout = {(state_q == ST_ACK), 6'b0, timer_en_q};
      endcase
    end
  end

  assign sel           = reset_n && (reg_sel || ack);
  assign irq_n         = irq_n_q;
  assign dbg_ack_state = (state_q == ST_ACK);

endmodule
